// File: rtl/cdc_2phase_clear_seq_if.sv
// Local handshake bundle of the clear sequencer: the request/acknowledge
// pair from the surrounding CDC half and the isolate/clear/status outputs.
interface cdc_2phase_clear_seq_if;
    logic clear_req_i;
    logic isolate_ack_i;
    logic isolate_o;
    logic clear_o;
    logic busy_o;
    logic clear_done_o;

    // Requester / CDC-half side.
    modport master (
        output clear_req_i,
        output isolate_ack_i,
        input  isolate_o,
        input  clear_o,
        input  busy_o,
        input  clear_done_o
    );

    // Sequencer side.
    modport slave (
        input  clear_req_i,
        input  isolate_ack_i,
        output isolate_o,
        output clear_o,
        output busy_o,
        output clear_done_o
    );
endinterface

// File: rtl/cdc_2phase_clear_seq.sv
// Destination-domain clear sequencer for a clearable two-phase CDC half.
// Walks IDLE -> ISOLATE -> CLEAR -> POST_CLEAR -> IDLE in lock-step with a
// peer sequencer in the other clock domain. Each entry into a non-idle
// state toggles the own phase; a step is left only once the synchronized
// peer phase matches it again, so the two sides never drift apart by more
// than one step. All outputs come straight from flops.
module cdc_2phase_clear_seq #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned POST_CYCLES  = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   async_phase_i,
    output logic                   async_phase_o,
    cdc_2phase_clear_seq_if.slave  seq
);

    localparam int unsigned MAX_A = (CLEAR_CYCLES > POST_CYCLES) ? CLEAR_CYCLES : POST_CYCLES;
    localparam int unsigned MAX_C = (MAX_A > 1) ? MAX_A : 1;
    localparam int unsigned CNT_W = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CLR_THR  = CNT_W'(CLEAR_CYCLES - 1);
    // With no settle time the threshold is zero, which any count satisfies.
    localparam logic [CNT_W-1:0] POST_THR = (POST_CYCLES == 0) ? CNT_W'(0) : CNT_W'(POST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISOLATE = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_POST    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   isolate_q, isolate_d;
    logic                   clear_q, clear_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   peer_ph_s;
    logic                   in_step_s;

    // Saturating increment so a long wait for the peer never wraps the count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    assign peer_ph_s = sync_q[SYNC_STAGES-1];
    assign in_step_s = (peer_ph_s == phase_q);

    // Next-state, phase, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_phase_i};
        case (state_q)
            ST_IDLE: begin
                // Local request or a peer that has already moved on; a
                // simultaneous start still produces a single toggle.
                if (seq.clear_req_i || !in_step_s) begin
                    state_d = ST_ISOLATE;
                    phase_d = ~phase_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISOLATE: begin
                if (seq.isolate_ack_i && in_step_s) begin
                    state_d = ST_CLEAR;
                    phase_d = ~phase_q;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_ISOLATE;
                end
            end
            ST_CLEAR: begin
                // Clear stays asserted past its minimum while the peer lags.
                if ((cnt_q >= CLR_THR) && in_step_s) begin
                    state_d = ST_POST;
                    phase_d = ~phase_q;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_POST: begin
                // Leaving to IDLE does not toggle: three toggles per sequence.
                if ((cnt_q >= POST_THR) && in_step_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        isolate_d = (state_d != ST_IDLE);
        clear_d   = (state_d == ST_CLEAR);
        busy_d    = (state_d != ST_IDLE);
    end

    // State, phase, synchronizer, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            cnt_q     <= CNT_ZERO;
            sync_q    <= '0;
            isolate_q <= 1'b0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            isolate_q <= isolate_d;
            clear_q   <= clear_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign async_phase_o    = phase_q;
    assign seq.isolate_o    = isolate_q;
    assign seq.clear_o      = clear_q;
    assign seq.busy_o       = busy_q;
    assign seq.clear_done_o = done_q;

endmodule
